// File: rtl/game_pkg.sv
// Keycode constants and key classification shared by the key shaper and the game FSM.
package game_pkg;
  localparam logic [7:0] KEY_NONE      = 8'h00;
  localparam logic [7:0] KEY_LEFT      = 8'h04;
  localparam logic [7:0] KEY_RIGHT     = 8'h07;
  localparam logic [7:0] KEY_LROT      = 8'h14;
  localparam logic [7:0] KEY_RROT      = 8'h08;
  localparam logic [7:0] KEY_SOFT_DROP = 8'h18;
  localparam logic [7:0] KEY_HOLD      = 8'h0F;
  localparam logic [7:0] KEY_KONAMI    = 8'h1A;
  localparam logic [7:0] KEY_CLEARALL  = 8'h13;

  typedef enum logic [1:0] {KC_NONE, KC_REPEAT, KC_LEVEL, KC_ONESHOT} key_class_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRESS_PEND, ST_DAS_WAIT, ST_REPEAT_PEND, ST_ARR_WAIT, ST_HELD, ST_LEVEL_HOLD
  } kes_state_t;

  function automatic key_class_t classify(input logic [7:0] code);
    if (code == KEY_NONE) return KC_NONE;
    if (code == KEY_LEFT || code == KEY_RIGHT) return KC_REPEAT;
    if (code == KEY_SOFT_DROP) return KC_LEVEL;
    return KC_ONESHOT;
  endfunction
endpackage

// File: rtl/key_event_shaper_if.sv
// Keyboard-to-game-FSM event channel: raw keycode in, held event with accept handshake out.
interface key_event_shaper_if;
  logic [7:0] keycode_raw;
  logic       stall_ready;
  logic [7:0] keycode_out;
  logic       key_valid;
  logic       key_accept;
  logic       repeat_active;

  modport master (output keycode_raw, stall_ready,
                  input  keycode_out, key_valid, key_accept, repeat_active);
  modport slave  (input  keycode_raw, stall_ready,
                  output keycode_out, key_valid, key_accept, repeat_active);
endinterface

// File: rtl/key_stability_filter.sv
// Passes a keycode through only after it has been sampled STABLE_CYCLES times in a row.
module key_stability_filter #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] keycode_raw,
  output logic [7:0] key_cur
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [7:0]    r_last;
  logic [7:0]    r_key;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  // run length of identical samples, saturating once stable
  always_comb begin
    if (keycode_raw != r_last)                w_cnt_next = CW'(1);
    else if (r_cnt == CW'(STABLE_CYCLES))     w_cnt_next = r_cnt;
    else                                      w_cnt_next = r_cnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_last <= '0;
      r_cnt  <= '0;
      r_key  <= '0;
    end else begin
      r_last <= keycode_raw;
      r_cnt  <= w_cnt_next;
      if (w_cnt_next == CW'(STABLE_CYCLES)) r_key <= keycode_raw;
    end
  end

  assign key_cur = r_key;
endmodule

// File: rtl/key_event_shaper.sv
// Turns the filtered keycode into one held event per press, with DAS/ARR repeat for left/right.
module key_event_shaper
  import game_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int DAS_CYCLES    = 8000000,
  parameter int ARR_CYCLES    = 1500000,
  parameter int CNT_W         = 24
) (
  input logic               CLK,
  input logic               RESET,
  key_event_shaper_if.slave kif
);
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

  kes_state_t       r_state, w_next, w_eval_state;
  logic [7:0]       r_code, w_code_next;
  logic [CNT_W-1:0] r_timer;
  logic [7:0]       w_key_cur;
  logic             w_valid, w_accept, w_rpt_active;
  logic [7:0]       w_code_out;

  key_stability_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .CLK         (CLK),
    .RESET       (RESET),
    .keycode_raw (kif.keycode_raw),
    .key_cur     (w_key_cur)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
    end else begin
      r_state <= w_next;
      r_code  <= w_code_next;
    end
  end

  // timer restarts on every state change and saturates instead of wrapping
  always_ff @(posedge CLK) begin
    if (RESET || (w_next != r_state)) r_timer <= '0;
    else if (r_timer != '1)           r_timer <= r_timer + 1'b1;
  end

  always_comb begin
    unique case (classify(w_key_cur))
      KC_NONE:  w_eval_state = ST_IDLE;
      KC_LEVEL: w_eval_state = ST_LEVEL_HOLD;
      default:  w_eval_state = ST_PRESS_PEND;
    endcase

    w_next      = r_state;
    w_code_next = r_code;
    unique case (r_state)
      ST_IDLE: begin
        w_next      = w_eval_state;
        w_code_next = w_key_cur;
      end
      // a first press is never dropped; any key change waits until it is taken
      ST_PRESS_PEND: begin
        if (w_accept) begin
          if (w_key_cur != r_code)              w_next = ST_IDLE;
          else if (classify(r_code) == KC_REPEAT) w_next = ST_DAS_WAIT;
          else                                  w_next = ST_HELD;
        end
      end
      default: begin
        if (w_key_cur != r_code) begin
          w_next      = w_eval_state;
          w_code_next = w_key_cur;
        end else begin
          unique case (r_state)
            ST_DAS_WAIT:    if (r_timer == DAS_LAST) w_next = ST_REPEAT_PEND;
            ST_ARR_WAIT:    if (r_timer == ARR_LAST) w_next = ST_REPEAT_PEND;
            ST_REPEAT_PEND: if (w_accept)            w_next = ST_ARR_WAIT;
            default:        w_next = r_state;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    w_valid      = (r_state == ST_PRESS_PEND) || (r_state == ST_REPEAT_PEND);
    w_accept     = w_valid && kif.stall_ready;
    w_rpt_active = (r_state == ST_ARR_WAIT) || (r_state == ST_REPEAT_PEND);
    if (w_valid)                        w_code_out = r_code;
    else if (r_state == ST_LEVEL_HOLD)  w_code_out = KEY_SOFT_DROP;
    else                                w_code_out = KEY_NONE;
  end

  assign kif.key_valid     = w_valid;
  assign kif.key_accept    = w_accept;
  assign kif.keycode_out   = w_code_out;
  assign kif.repeat_active = w_rpt_active;
endmodule

// File: tb/tb_key_event_shaper.sv
// Randomized and directed bench for key_event_shaper against an event-level reference model.
module tb_key_event_shaper;
  localparam int STABLE = 2;
  localparam int DAS    = 10;
  localparam int ARR    = 4;

  logic CLK = 1'b0;
  logic RESET;
  key_event_shaper_if kif ();

  key_event_shaper #(
    .STABLE_CYCLES (STABLE),
    .DAS_CYCLES    (DAS),
    .ARR_CYCLES    (ARR),
    .CNT_W         (24)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .kif   (kif)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: sliding sample window for the filter, then one tracked key
  // with a pending flag and a countdown to its next repeat.
  logic [7:0] m_hist [STABLE];
  logic [7:0] m_kcur;
  logic [7:0] m_code;
  bit         m_pend, m_first, m_arr;
  int         m_left;

  function automatic bit is_rep(input logic [7:0] c);
    return (c == 8'h04) || (c == 8'h07);
  endfunction

  task automatic model_clear();
    foreach (m_hist[i]) m_hist[i] = 8'h00;
    m_kcur = 8'h00; m_code = 8'h00;
    m_pend = 0; m_first = 0; m_arr = 0; m_left = 0;
  endtask

  task automatic model_edge(input logic [7:0] raw, input bit stall, input bit rst);
    logic [7:0] kc;
    bit acc, same;
    if (rst) begin
      model_clear();
      return;
    end
    kc  = m_kcur;
    acc = m_pend && stall;
    if (m_pend && m_first) begin
      if (acc) begin
        m_pend = 0; m_first = 0; m_arr = 0;
        if (kc != m_code) m_code = 8'h00;
        else              m_left = DAS;
      end
    end else if (kc != m_code) begin
      m_code  = kc;
      m_arr   = 0;
      m_pend  = (kc != 8'h00) && (kc != 8'h18);
      m_first = m_pend;
    end else if (is_rep(m_code)) begin
      if (m_pend) begin
        if (acc) begin m_pend = 0; m_arr = 1; m_left = ARR; end
      end else begin
        m_left--;
        if (m_left == 0) m_pend = 1;
      end
    end
    for (int i = 0; i < STABLE - 1; i++) m_hist[i] = m_hist[i+1];
    m_hist[STABLE-1] = raw;
    same = 1;
    foreach (m_hist[i]) if (m_hist[i] != raw) same = 0;
    if (same) m_kcur = raw;
  endtask

  int         cyc_n;
  int         acc_cyc[$];
  logic [7:0] acc_code[$];

  task automatic scen_clear();
    cyc_n = 0;
    acc_cyc.delete();
    acc_code.delete();
  endtask

  task automatic step(input logic [7:0] raw, input bit stall, input bit rst);
    logic [7:0] e_code;
    @(negedge CLK);
    kif.keycode_raw = raw;
    kif.stall_ready = stall;
    RESET           = rst;
    #1;
    e_code = m_pend ? m_code : ((m_code == 8'h18) ? 8'h18 : 8'h00);
    chk("valid",  kif.key_valid,     m_pend);
    chk("code",   kif.keycode_out,   e_code);
    chk("accept", kif.key_accept,    m_pend && stall);
    chk("rpt",    kif.repeat_active, (m_pend && !m_first) || (m_arr && !m_pend));
    if (kif.key_accept === 1'b1) begin
      acc_cyc.push_back(cyc_n);
      acc_code.push_back(kif.keycode_out);
    end
    @(posedge CLK);
    model_edge(raw, stall, rst);
    cyc_n++;
  endtask

  task automatic hold(input logic [7:0] raw, input bit stall, input int n);
    for (int i = 0; i < n; i++) step(raw, stall, 1'b0);
  endtask

  function automatic logic [7:0] code_at(input int i);
    return (acc_code.size() > i) ? acc_code[i] : 8'hEE;
  endfunction

  function automatic int cyc_at(input int i);
    return (acc_cyc.size() > i) ? acc_cyc[i] : -100;
  endfunction

  logic [7:0] tbl [10];
  int f0, f1, dur;
  logic [7:0] rk;

  initial begin
    tbl[0] = 8'h00; tbl[1] = 8'h04; tbl[2] = 8'h07; tbl[3] = 8'h14; tbl[4] = 8'h08;
    tbl[5] = 8'h0F; tbl[6] = 8'h1A; tbl[7] = 8'h13; tbl[8] = 8'h18; tbl[9] = 8'h00;
    kif.keycode_raw = 8'h00;
    kif.stall_ready = 1'b0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    model_clear();

    // tap of a oneshot key
    hold(8'h00, 1, 6); scen_clear();
    hold(8'h14, 1, 3); hold(8'h00, 1, 8);
    chk("s1_count", acc_cyc.size(), 1);
    chk("s1_code",  code_at(0), 8'h14);
    chk("s1_lat",   cyc_at(0), 3);

    // held left: DAS then ARR repeats
    scen_clear();
    hold(8'h04, 1, 40); hold(8'h00, 1, 10);
    chk("s2_count", acc_cyc.size(), 7);
    chk("s2_das",   cyc_at(1) - cyc_at(0), 11);
    chk("s2_arr",   cyc_at(2) - cyc_at(1), 5);

    // short press while FSM busy survives until stall_ready
    scen_clear();
    hold(8'h07, 0, 2); hold(8'h00, 0, 20); hold(8'h00, 1, 6);
    chk("s3_count", acc_cyc.size(), 1);
    chk("s3_code",  code_at(0), 8'h07);

    // clear-all once per press, soft drop as a level
    scen_clear();
    hold(8'h13, 1, 100);
    chk("s4_count", acc_cyc.size(), 1);
    chk("s4_code",  code_at(0), 8'h13);
    scen_clear();
    hold(8'h18, 1, 20);
    chk("s4_lvl_out", kif.keycode_out, 8'h18);
    hold(8'h00, 1, 6);
    chk("s4_lvl_acc", acc_cyc.size(), 0);

    // switch 04 -> 07 during ARR restarts DAS
    scen_clear();
    hold(8'h04, 1, 20); hold(8'h07, 1, 30); hold(8'h00, 1, 8);
    f0 = -1; f1 = -1;
    foreach (acc_code[i])
      if (acc_code[i] == 8'h07) begin
        if (f0 < 0) f0 = acc_cyc[i];
        else if (f1 < 0) f1 = acc_cyc[i];
      end
    chk("s5_lat", f0 - 20, 3);
    chk("s5_das", f1 - f0, 11);

    // reset while a repeat is pending
    hold(8'h04, 1, 14); hold(8'h04, 0, 2);
    chk("s6_pend", kif.key_valid, 1'b1);
    step(8'h04, 0, 1'b1);
    scen_clear();
    hold(8'h04, 1, 8);
    chk("s6_lat", cyc_at(0), 3);
    hold(8'h00, 1, 6);

    // random traffic with occasional resets
    for (int n = 0; n < 150; n++) begin
      rk  = (($urandom % 8) == 0) ? 8'($urandom) : tbl[$urandom % 10];
      dur = $urandom_range(1, 30);
      for (int j = 0; j < dur; j++)
        step(rk, ($urandom % 10) < 7, ($urandom % 250) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
